// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module  : mem_port_arbiter_pkg
// Brief   : Shared constants, FSM state type and a small index helper for the
//           program/data memory port arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    // Default geometry of the 1Kx16 program/data memory
    localparam int DEF_NUM_REQ = 3;
    localparam int DEF_AW      = 10;
    localparam int DEF_DW      = 16;

    // Requester slot assignment on the shared port
    localparam int REQ_CORE = 0;
    localparam int REQ_I2C  = 1;
    localparam int REQ_PWM  = 2;

    // Arbiter FSM encoding
    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // Next requester index after idx, wrapping at n
    function automatic int wrap_inc(input int idx, input int n);
        return ((idx + 1) >= n) ? 0 : (idx + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Module  : mem_port_arbiter_if
// Brief   : Requester-side and memory-side signals of the shared memory port.
//           slave  = arbiter view, master = requesters plus memory view.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW
);
    // Requester side (requester k packed at [k*AW +: AW] / [k*DW +: DW])
    logic [NUM_REQ-1:0]    req_i;
    logic [NUM_REQ-1:0]    we_i;
    logic [NUM_REQ*AW-1:0] addr_i;
    logic [NUM_REQ*DW-1:0] wdata_i;
    logic [NUM_REQ-1:0]    lock_i;
    logic [NUM_REQ-1:0]    gnt_o;
    logic [NUM_REQ-1:0]    rvalid_o;
    logic [DW-1:0]         rdata_o;

    // Memory side
    logic [AW-1:0]         mem_addr_o;
    logic [DW-1:0]         mem_wdata_o;
    logic                  mem_we_o;
    logic [DW-1:0]         mem_rdata_i;

    modport slave (
        input  req_i, we_i, addr_i, wdata_i, lock_i, mem_rdata_i,
        output gnt_o, rvalid_o, rdata_o, mem_addr_o, mem_wdata_o, mem_we_o
    );

    modport master (
        output req_i, we_i, addr_i, wdata_i, lock_i, mem_rdata_i,
        input  gnt_o, rvalid_o, rdata_o, mem_addr_o, mem_wdata_o, mem_we_o
    );

endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_pick.sv
// ============================================================================
// Module  : mem_port_arbiter_rr_pick
// Brief   : Combinational rotate-priority picker. Scans the request vector
//           starting at start_i, wrapping modulo NUM_REQ, and returns the first
//           set requester as a one-hot grant plus its index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter_rr_pick #(
    parameter int NUM_REQ = 3,
    parameter int IW      = 2
) (
    input  wire logic [NUM_REQ-1:0] req_i,
    input  wire logic [IW-1:0]      start_i,
    output logic      [NUM_REQ-1:0] gnt_o,
    output logic      [IW-1:0]      idx_o,
    output logic                    any_o
);

    // First requester at or after start_i (circularly) wins
    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = int'(start_i) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (!any_o && req_i[j[IW-1:0]]) begin
                any_o             = 1'b1;
                gnt_o[j[IW-1:0]]  = 1'b1;
                idx_o             = j[IW-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module  : mem_port_arbiter
// Brief   : Shares the single program/data memory port among NUM_REQ
//           requesters. At most one grant per clock, combinational one-hot
//           grant, memory address/data/write-enable muxed from the winner,
//           registered read data with a one-hot valid one cycle later.
//           Optional burst locking is built when MEM_ARB_BURST_EN is defined;
//           without it lock_i is ignored and every grant is single-cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW,
    parameter int PRIO_MODE = 0,
    parameter int MAX_BURST = 8
) (
    input  wire logic            clk_io,
    input  wire logic            reset_io,
    mem_port_arbiter_if.slave    bus
);

    localparam int IW = $clog2(NUM_REQ);

    logic [IW-1:0]      rr_ptr_q;
    logic [IW-1:0]      rr_ptr_d;
    logic [NUM_REQ-1:0] rvalid_q;
    logic [DW-1:0]      rdata_q;

    logic [IW-1:0]      w_start;
    logic [NUM_REQ-1:0] w_pick_gnt;
    logic [IW-1:0]      w_pick_idx;
    logic               w_pick_any;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IW-1:0]      w_idx;
    logic               w_any;
    logic               w_rd;
    logic               w_wr;

`ifdef MEM_ARB_BURST_EN
    localparam int              BCW        = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [BCW-1:0]  BURST_LAST = BCW'(MAX_BURST - 1);

    arb_state_e     state_q;
    logic [IW-1:0]  owner_q;
    logic [BCW-1:0] burst_cnt_q;
    logic           w_owner_go;

    // Burst continues only while the owner keeps both request and lock up
    assign w_owner_go = bus.req_i[owner_q] & bus.lock_i[owner_q];
`else
    logic unused_lock;

    assign unused_lock = ^bus.lock_i;
`endif

    // Fixed priority always scans from requester 0
    assign w_start = (PRIO_MODE != 0) ? '0 : rr_ptr_q;

    mem_port_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_pick (
        .req_i   (bus.req_i),
        .start_i (w_start),
        .gnt_o   (w_pick_gnt),
        .idx_o   (w_pick_idx),
        .any_o   (w_pick_any)
    );

    // Winner of this cycle: burst owner when locked, otherwise the picker
    always_comb begin
        w_gnt = '0;
        w_idx = '0;
`ifdef MEM_ARB_BURST_EN
        if (state_q == ST_BURST) begin
            if (w_owner_go) begin
                w_gnt[owner_q] = 1'b1;
                w_idx          = owner_q;
            end
        end else if (w_pick_any) begin
            w_gnt = w_pick_gnt;
            w_idx = w_pick_idx;
        end
`else
        if (w_pick_any) begin
            w_gnt = w_pick_gnt;
            w_idx = w_pick_idx;
        end
`endif
        // No access may reach the memory while reset is held
        if (!reset_io) begin
            w_gnt = '0;
            w_idx = '0;
        end
    end

    assign w_any = |w_gnt;
    assign w_wr  = w_any &  bus.we_i[w_idx];
    assign w_rd  = w_any & ~bus.we_i[w_idx];

    assign bus.gnt_o       = w_gnt;
    assign bus.mem_we_o    = w_wr;
    assign bus.mem_addr_o  = w_any ? bus.addr_i[int'(w_idx)*AW +: AW]  : '0;
    assign bus.mem_wdata_o = w_any ? bus.wdata_i[int'(w_idx)*DW +: DW] : '0;
    assign bus.rvalid_o    = rvalid_q;
    assign bus.rdata_o     = rdata_q;

    // Round-robin pointer moves past whoever was served; a burst always hands over past its owner
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_any) begin
            rr_ptr_d = IW'(wrap_inc(int'(w_idx), NUM_REQ));
        end
`ifdef MEM_ARB_BURST_EN
        if (state_q == ST_BURST) begin
            rr_ptr_d = IW'(wrap_inc(int'(owner_q), NUM_REQ));
        end
`endif
    end

    // Arbiter state, pointer and registered read-return path
    always_ff @(posedge clk_io or negedge reset_io) begin
        if (!reset_io) begin
            rr_ptr_q    <= '0;
            rvalid_q    <= '0;
            rdata_q     <= '0;
`ifdef MEM_ARB_BURST_EN
            state_q     <= ST_ARB;
            owner_q     <= '0;
            burst_cnt_q <= '0;
`endif
        end else begin
            rr_ptr_q <= rr_ptr_d;
            rvalid_q <= w_rd ? w_gnt : '0;
            if (w_rd) begin
                rdata_q <= bus.mem_rdata_i;
            end
`ifdef MEM_ARB_BURST_EN
            case (state_q)
                ST_ARB: begin
                    if (w_any && bus.lock_i[w_idx] && (MAX_BURST > 1)) begin
                        state_q     <= ST_BURST;
                        owner_q     <= w_idx;
                        burst_cnt_q <= BCW'(1);
                    end
                end
                ST_BURST: begin
                    if (w_owner_go && (burst_cnt_q != BURST_LAST)) begin
                        burst_cnt_q <= burst_cnt_q + 1'b1;
                    end else begin
                        state_q     <= ST_ARB;
                        burst_cnt_q <= '0;
                    end
                end
            endcase
`endif
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module  : tb_mem_port_arbiter
// Brief   : Self-checking bench for mem_port_arbiter: directed scenarios plus
//           randomized requesters against a queue/array reference model, with
//           a scoreboard monitor for the read-return path. A second instance in
//           fixed-priority mode shares the request inputs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int N  = 3;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int MB = 8;

    logic clk_io   = 1'b0;
    logic reset_io = 1'b1;
    logic mem_clr  = 1'b1;
    int   cyc      = 0;
    int   n_chk    = 0;
    int   n_fail   = 0;

    always #5 clk_io = ~clk_io;
    always @(posedge clk_io) cyc <= cyc + 1;

    mem_port_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) ifm ();
    mem_port_arbiter_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) ifx ();

    mem_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .PRIO_MODE(0), .MAX_BURST(MB)) dut (
        .clk_io   (clk_io),
        .reset_io (reset_io),
        .bus      (ifm)
    );

    mem_port_arbiter #(.NUM_REQ(N), .AW(AW), .DW(DW), .PRIO_MODE(1), .MAX_BURST(MB)) dut_fx (
        .clk_io   (clk_io),
        .reset_io (reset_io),
        .bus      (ifx)
    );

    // Fixed-priority instance sees the same requests, never locked, no memory
    assign ifx.req_i       = ifm.req_i;
    assign ifx.we_i        = ifm.we_i;
    assign ifx.addr_i      = ifm.addr_i;
    assign ifx.wdata_i     = ifm.wdata_i;
    assign ifx.lock_i      = '0;
    assign ifx.mem_rdata_i = '0;

    // Memory attached to the main instance: async read, write at posedge
    logic [DW-1:0] mem [0:1023];
    assign ifm.mem_rdata_i = mem[ifm.mem_addr_o];
    always @(posedge clk_io) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= '0;
        end else if (ifm.mem_we_o) begin
            mem[ifm.mem_addr_o] <= ifm.mem_wdata_o;
        end
    end

    // Requester behaviour
    bit            pend  [N];
    bit            hold  [N];
    bit            plock [N];
    logic          pwe   [N];
    logic [AW-1:0] paddr [N];
    logic [DW-1:0] pwd   [N];

    // Reference model
    logic [DW-1:0] ref_mem [0:1023];
    int rr       = 0;
    bit in_burst = 0;
    int owner    = 0;
    int bcnt     = 0;

    typedef struct {
        int            due;
        int            idx;
        logic [DW-1:0] data;
    } rexp_t;
    rexp_t rq [$];

    logic [N-1:0] last_gnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] cur_req();
        logic [N-1:0] v;
        for (int k = 0; k < N; k++) v[k] = pend[k];
        return v;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            ifm.req_i[k]             = pend[k];
            ifm.we_i[k]              = pwe[k];
            ifm.lock_i[k]            = plock[k];
            ifm.addr_i[k*AW +: AW]   = paddr[k];
            ifm.wdata_i[k*DW +: DW]  = pwd[k];
        end
    endtask

    // Who should be served this cycle, from the arbitration rules
    function automatic int model_pick();
        if (!reset_io) return -1;
`ifdef MEM_ARB_BURST_EN
        if (in_burst) return (pend[owner] && plock[owner]) ? owner : -1;
`endif
        for (int i = 0; i < N; i++) begin
            if (pend[(rr + i) % N]) return (rr + i) % N;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
`ifdef MEM_ARB_BURST_EN
        if (in_burst) begin
            if (g >= 0) begin
                bcnt++;
                if (bcnt == MB) in_burst = 0;
            end else begin
                in_burst = 0;
            end
            rr = (owner + 1) % N;
            return;
        end
`endif
        if (g >= 0) begin
            rr = (g + 1) % N;
`ifdef MEM_ARB_BURST_EN
            if (plock[g] && MB > 1) begin
                in_burst = 1;
                owner    = g;
                bcnt     = 1;
            end
`endif
        end
    endtask

    // One clock: check combinational outputs mid-cycle, advance model, update requesters
    task automatic step();
        int           g;
        logic [N-1:0] eg;
        logic [N-1:0] rv;
        @(negedge clk_io);
        rv = cur_req();
        g  = model_pick();
        eg = '0;
        if (g >= 0) eg[g] = 1'b1;
        last_gnt = ifm.gnt_o;
        chk("gnt", ifm.gnt_o, eg);
        chk("mem_we", ifm.mem_we_o, (g >= 0) ? pwe[g] : 1'b0);
        chk("mem_addr", ifm.mem_addr_o, (g >= 0) ? paddr[g] : '0);
        chk("mem_wdata", ifm.mem_wdata_o, (g >= 0) ? pwd[g] : '0);
        chk("gnt_fixed", ifx.gnt_o, reset_io ? (rv & (~rv + 1'b1)) : '0);
        if (g >= 0) begin
            if (pwe[g]) ref_mem[paddr[g]] = pwd[g];
            else        rq.push_back('{cyc + 1, g, ref_mem[paddr[g]]});
        end
        model_update(g);
        @(posedge clk_io);
        #1;
        if (g >= 0 && !hold[g]) pend[g] = 0;
        drive();
    endtask

    task automatic reset_pulse();
        reset_io = 1'b0;
        rr       = 0;
        in_burst = 0;
        bcnt     = 0;
        rq.delete();
        #1;
        chk("rst_rvalid", ifm.rvalid_o, '0);
        chk("rst_rdata", ifm.rdata_o, '0);
        step();
        reset_io = 1'b1;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < N; k++) begin
            pend[k]  = 0;
            hold[k]  = 0;
            plock[k] = 0;
        end
        drive();
    endtask

    task automatic set_req(input int k, input logic we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input bit lk, input bit hd);
        pend[k]  = 1;
        pwe[k]   = we;
        paddr[k] = a;
        pwd[k]   = d;
        plock[k] = lk;
        hold[k]  = hd;
    endtask

    // Scoreboard monitor for the read-return path
    initial begin
        logic [N-1:0]  erv;
        logic [DW-1:0] ed;
        bit            have;
        forever begin
            @(negedge clk_io);
            erv  = '0;
            ed   = '0;
            have = 0;
            if (rq.size() > 0 && rq[0].due == cyc) begin
                erv[rq[0].idx] = 1'b1;
                ed             = rq[0].data;
                have           = 1;
                void'(rq.pop_front());
            end
            chk("rvalid", ifm.rvalid_o, erv);
            if (have) chk("rdata", ifm.rdata_o, ed);
        end
    end

    initial begin
        logic [N-1:0] t3 [6];
        int           n2;
        t3 = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
        for (int k = 0; k < N; k++) begin
            pend[k] = 0; hold[k] = 0; plock[k] = 0;
            pwe[k] = 0; paddr[k] = '0; pwd[k] = '0;
        end

        // Reset held with every requester asking
        for (int k = 0; k < N; k++) set_req(k, 1'b1, 10'(k), 16'h1111, 0, 1);
        drive();
        #2;
        reset_pulse();
        mem_clr = 1'b0;
        clear_reqs();

        // Write then read back through requester 0
        set_req(0, 1'b1, 10'h005, 16'hBEEF, 0, 0);
        drive();
        step();
        set_req(0, 1'b0, 10'h005, 16'h0000, 0, 0);
        drive();
        step();
        chk("t2_rvalid", ifm.rvalid_o, 3'b001);
        chk("t2_rdata", ifm.rdata_o, 16'hBEEF);
        chk("t2_mem5", mem[5], 16'hBEEF);
        step();

        // All requesting continuously: round-robin rotation
        reset_pulse();
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 10'(k), '0, 0, 1);
        drive();
        for (int i = 0; i < 6; i++) begin
            step();
            chk("t3_rr_seq", last_gnt, t3[i]);
        end
        clear_reqs();

        // Pointer wrap after a lone grant to requester 1
        set_req(1, 1'b0, 10'h3FF, '0, 0, 0);
        drive();
        step();
        chk("t4_gnt1", last_gnt, 3'b010);
        for (int k = 0; k < N; k++) set_req(k, 1'b0, 10'h3FF, '0, 0, 1);
        drive();
        step();
        chk("t4_wrap_a", last_gnt, 3'b100);
        step();
        chk("t4_wrap_b", last_gnt, 3'b001);
        clear_reqs();

        // Locked requester 2 competing with requester 0 for 12 cycles
        reset_pulse();
        set_req(0, 1'b0, 10'h001, '0, 0, 1);
        set_req(2, 1'b0, 10'h002, '0, 1, 1);
        drive();
        n2 = 0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_gnt == 3'b100) n2++;
`ifdef MEM_ARB_BURST_EN
            if (i == 9) chk("t5_after_burst", last_gnt, 3'b001);
`endif
        end
`ifdef MEM_ARB_BURST_EN
        chk("t5_grants_to_2", n2, 10);
`else
        chk("t5_grants_to_2", n2, 6);
`endif
        clear_reqs();

        // Reset in the middle of a locked sequence
        reset_pulse();
        set_req(2, 1'b0, 10'h007, '0, 1, 1);
        drive();
        step();
        step();
        step();
        set_req(0, 1'b0, 10'h001, '0, 0, 1);
        drive();
        reset_pulse();
        step();
        chk("t6_post_reset_lowest", last_gnt, 3'b001);
        clear_reqs();

        // Randomized requesters
        for (int c = 0; c < 1500; c++) begin
            for (int k = 0; k < N; k++) begin
                if (!pend[k]) begin
                    if ($urandom_range(0, 99) < 35) begin
                        set_req(k, 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 7) == 0) ? 10'h3FF : 10'($urandom_range(0, 15)),
                                16'($urandom), ($urandom_range(0, 3) == 0),
                                ($urandom_range(0, 4) == 0));
                    end
                end else begin
                    if (hold[k] && $urandom_range(0, 9) == 0) hold[k] = 0;
                    if (!hold[k] && $urandom_range(0, 19) == 0) pend[k] = 0;
                    if ($urandom_range(0, 15) == 0) plock[k] = ~plock[k];
                end
            end
            drive();
            step();
        end

        clear_reqs();
        step();
        step();
        step();
        chk("rq_drained", rq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
